// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline interlock controller.
//   sb_entry_t : one scoreboard slot, {valid, destination register}
//   REG_ZERO   : hard-wired zero register, never a hazard source
//   NSTAGE_SB  : number of scoreboard slots (Ex, Mem, Wr)
package pipe_pkg;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         NSTAGE_SB = 3;

  // True when the slot holds a pending write to register r.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
    return e.v && (e.dst == r);
  endfunction

  function automatic sb_entry_t mk_entry(input logic v, input logic [4:0] dst);
    sb_entry_t e;
    e.v   = v;
    e.dst = dst;
    return e;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of signals between the pipeline stage modules and the
// interlock/flush controller.
//   master : stage side, drives the ID-stage fields and jumpen,
//            receives hold/bubble/flush controls and counters
//   slave  : controller side
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_regwr;
  logic [4:0]       id_dst;
  logic             jumpen;

  logic             stall_pc;
  logic             stall_ifid;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwr, id_dst, jumpen,
    input  stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, flush_exmem,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwr, id_dst, jumpen,
    output stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, flush_exmem,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_cmp.sv
// Combinational compare of one 5-bit source register against the three
// scoreboard slots.
//   src, use_src            : source register and whether it is read
//   sb_ex, sb_mem, sb_wr    : scoreboard slots
//   hit                     : source depends on a pending write
// With WB_BYPASS the register file writes through, so the Wr slot is ignored.
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic [4:0] src,
  input  logic       use_src,
  input  sb_entry_t  sb_ex,
  input  sb_entry_t  sb_mem,
  input  sb_entry_t  sb_wr,
  output logic       hit
);

  logic wr_hit;

  assign wr_hit = WB_BYPASS ? 1'b0 : sb_match(sb_wr, src);
  assign hit    = use_src && (src != REG_ZERO) &&
                  (sb_match(sb_ex, src) || sb_match(sb_mem, src) || wr_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and flush controller for the five-stage pipeline.
// Tracks pending register writes of the instructions in Ex, Mem and Wr,
// holds IF/ID and bubbles ID/Ex on a read-after-write hazard (no forwarding
// in the datapath), and squashes wrong-path instructions when Mem resolves
// a taken redirect.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : ID-stage instruction fields and jumpen in;
//                    stall_pc/stall_ifid/bubble_idex, flush_* and the
//                    stall/flush event counters out
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  sb_entry_t        sb_ex, sb_mem, sb_wr;
  sb_entry_t        sb_ex_nxt, sb_mem_nxt, sb_wr_nxt;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             rs_hit, rt_hit, haz, stall, redirect;

  hazard_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rs (
    .src     (bus.id_rs),
    .use_src (bus.id_use_rs),
    .sb_ex   (sb_ex),
    .sb_mem  (sb_mem),
    .sb_wr   (sb_wr),
    .hit     (rs_hit)
  );

  hazard_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rt (
    .src     (bus.id_rt),
    .use_src (bus.id_use_rt),
    .sb_ex   (sb_ex),
    .sb_mem  (sb_mem),
    .sb_wr   (sb_wr),
    .hit     (rt_hit)
  );

  // Redirect outranks the interlock: the stalled instruction is wrong-path.
  assign haz      = bus.id_valid && (rs_hit || rt_hit);
  assign redirect = bus.jumpen;
  assign stall    = haz && !redirect;

  assign bus.stall_pc    = stall;
  assign bus.stall_ifid  = stall;
  assign bus.bubble_idex = stall;
  assign bus.flush_ifid  = redirect;
  assign bus.flush_idex  = redirect;
  assign bus.flush_exmem = redirect;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

  // Scoreboard advance: Ex gets a bubble unless a fresh instruction issues;
  // on redirect the Ex occupant is wrong-path, but the Mem occupant (the
  // jumping instruction, e.g. JCALL writing $31) still retires into Wr.
  always_comb begin
    sb_ex_nxt  = mk_entry(1'b0, REG_ZERO);
    sb_mem_nxt = sb_ex;
    sb_wr_nxt  = sb_mem;
    if (redirect) begin
      sb_mem_nxt = mk_entry(1'b0, REG_ZERO);
    end else if (!stall) begin
      sb_ex_nxt = mk_entry(bus.id_valid && bus.id_regwr && (bus.id_dst != REG_ZERO),
                           bus.id_dst);
    end
  end

  // Registered scoreboard and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex       <= mk_entry(1'b0, REG_ZERO);
      sb_mem      <= mk_entry(1'b0, REG_ZERO);
      sb_wr       <= mk_entry(1'b0, REG_ZERO);
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_ex  <= sb_ex_nxt;
      sb_mem <= sb_mem_nxt;
      sb_wr  <= sb_wr_nxt;
      if (stall)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Interlock and flush controller for the five-stage pipeline (IF, ID, Ex, Mem, Wr). It tracks outstanding register writes in a 3-entry scoreboard and stalls IF/ID on read-after-write hazards, because the datapath has no forwarding. It flushes the wrong-path instructions when the Mem stage resolves a taken jump or branch (`JUMPEN`). It sits beside the stage modules in `cpu` and drives their hold and bubble controls.

## Interface
- `WB_BYPASS`, default 0: 1 means the register file is write-through, so the instruction in Wr never causes a hazard.
- `CNT_W`, default 32: width of the performance counters.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction (not a bubble).
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_use_rs` in 1: the ID instruction reads rs.
- `id_use_rt` in 1: the ID instruction reads rt.
- `id_regwr` in 1: the ID instruction writes a register (`REGWR`).
- `id_dst` in 5: destination register after `REGDST`/`JCALL` selection.
- `jumpen` in 1: taken redirect resolved in Mem (`JUMPEN`).
- `stall_pc` out 1: hold the PC.
- `stall_ifid` out 1: hold the IF/ID register.
- `bubble_idex` out 1: load a NOP into ID/Ex (clears all control bits).
- `flush_ifid` out 1: squash IF/ID.
- `flush_idex` out 1: squash ID/Ex.
- `flush_exmem` out 1: squash Ex/Mem.
- `stall_cnt` out CNT_W: number of stall cycles.
- `flush_cnt` out CNT_W: number of redirect events.

## Operation
- **Scoreboard.** Three entries, `sb_ex`, `sb_mem` and `sb_wr`, each holding {v, dst}. Each entry is the pending write of the instruction currently in that stage.
- **Hazard (combinational).** `haz` = `id_valid` AND (rs_hit OR rt_hit).
  - rs_hit = `id_use_rs` AND `id_rs`≠0 AND `id_rs` matches the dst of any valid entry among ex and mem, plus wr when WB_BYPASS=0.
  - rt_hit is defined the same way using rt.
  - Register 0 never causes a hazard.
- **Stall** (`haz` AND NOT `jumpen`):
  - `stall_pc`=`stall_ifid`=`bubble_idex`=1.
  - Scoreboard update: ex←{0,0}, mem←ex, wr←mem.
- **Redirect** (`jumpen`=1). Redirect has priority over stall, so all stall outputs are 0.
  - `flush_ifid`=`flush_idex`=`flush_exmem`=1.
  - Scoreboard update: ex←{0,0}, mem←{0,0} (the Ex instruction is wrong-path), wr←mem (the jumping instruction itself may write, e.g. JCALL).
- **Normal cycle.**
  - ex←{`id_valid` AND `id_regwr` AND `id_dst`≠0, `id_dst`}.
  - mem←ex, wr←mem.
- **Counters.**
  - `stall_cnt` increments on each stall cycle.
  - `flush_cnt` increments on each `jumpen` cycle.
  - Both wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from the current scoreboard and the ID/`jumpen` inputs. They are valid in the same cycle and are sampled by the stage registers at the next `posedge clk`.
- The scoreboard and counters are registered and update on `posedge clk`.
- Reset:
  - Clears all scoreboard entries and both counters to 0.
  - Control outputs therefore read 0 in the first cycle after reset unless `jumpen`=1.
  - Asserting `rst` mid-stall discards pending hazards; there is no stall in the next cycle.
- Stall length after a producer issues:
  - WB_BYPASS=0: 3 cycles for an immediately dependent instruction, 2 at distance 2, 1 at distance 3.
  - WB_BYPASS=1: 2, 1 and 0 cycles respectively.
- `jumpen` on the same cycle as `haz`: flush only; the hazard is not counted.
- Simultaneous `rst` and `jumpen`: reset wins; counters stay 0.

## Structure
- Shared package `pipe_pkg`:
  - `sb_entry_t` {logic v; logic [4:0] dst}.
  - `REG_ZERO`=5'd0.
  - `NSTAGE_SB`=3.
- One natural sub-module, `hazard_cmp`: a combinational 5-bit source against 3-entry compare, instantiated twice (rs and rt).

## Test plan
- **RAW, distance 1, WB_BYPASS=0.**
  - Stimulus: `add $3` followed by `sub` reading $3.
  - Expected: `stall_pc` high for exactly 3 cycles; `stall_cnt`=3; the dependent instruction enters Ex on the 4th cycle.
- **Register-0 and bypass.**
  - Writer to $0 followed by a reader of $0: no stall.
  - WB_BYPASS=1, RAW at distance 1: exactly 2 stall cycles.
- **Redirect.** `jumpen` pulse for one cycle.
  - All three flush outputs are 1 for that cycle; `flush_cnt`=1.
  - Ex's pending write to $5 is dropped, so a later reader of $5 does not stall on it.
- **Jump during stall.** Hold a hazard on $7, then assert `jumpen` on the 2nd stall cycle.
  - Stall outputs are 0 that cycle; `stall_cnt`=1; the scoreboard's mem entry is cleared.
- **JCALL writes $31 through the redirect.**
  - The wr entry keeps dst=31 after `jumpen`.
  - A reader of $31 in the next cycle stalls 1 cycle (WB_BYPASS=0).
- **Reset mid-stall.** Assert `rst` during the 2nd cycle of a 3-cycle stall.
  - Next cycle: all outputs 0 and both counters 0.
